// File: rtl/regfft_seq.sv
// Frame sequencer for a 64x38 FFT register file: fills 64 samples, then drains
// them through a 2-entry skid buffer. Define REGFFT_BITREV_EN for bit-reversed read order.
module regfft_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [37:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [37:0] out_data,
  output logic        out_last,
  output logic        regfft_wren,
  output logic [5:0]  regfft_addr,
  output logic [37:0] regfft_wdata,
  input  logic [37:0] regfft_rdata
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [5:0]        wr_cnt;
  logic [6:0]        rd_cnt;      // bit 6 set once all 64 reads are issued
  logic              rd_pend, rd_pend_last;
  logic [1:0]        buf_cnt;
  logic [1:0][37:0]  buf_data;
  logic [1:0]        buf_last;
  logic              accept, pop, issue;
  logic [2:0]        occ;

  function automatic logic [5:0] rd_map(input logic [5:0] idx);
`ifdef REGFFT_BITREV_EN
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = idx[5-b];
    return r;
`else
    return idx;
`endif
  endfunction

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  // Occupancy after this cycle's pop, so a read can overlap a pop without bubbles.
  assign occ    = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign issue  = (state == DRAIN) && !rd_cnt[6] && (occ < 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && wr_cnt == 6'd63) state_nxt = DRAIN;
      DRAIN:   if (pop && buf_last[0])        state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    regfft_wren  = 1'b0;
    regfft_addr  = 6'd0;
    regfft_wdata = 38'd0;
    if (rst_n) begin
      if (state == FILL) begin
        in_ready     = 1'b1;
        regfft_wren  = in_valid;
        regfft_addr  = wr_cnt;
        regfft_wdata = in_data;
      end else begin
        regfft_addr  = rd_map(rd_cnt[5:0]);
      end
    end
  end

  assign out_valid = rst_n && (buf_cnt != 2'd0);
  assign out_data  = rst_n ? buf_data[0] : 38'd0;
  assign out_last  = rst_n && buf_last[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      wr_cnt       <= 6'd0;
      rd_cnt       <= 7'd0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      buf_cnt      <= 2'd0;
      buf_data     <= '0;
      buf_last     <= '0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= issue;
      rd_pend_last <= issue && (rd_cnt[5:0] == 6'd63);
      if (accept) wr_cnt <= wr_cnt + 6'd1;
      if (issue)
        rd_cnt <= rd_cnt + 7'd1;
      else if (state == DRAIN && state_nxt == FILL)
        rd_cnt <= 7'd0;
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
        buf_last[1] <= 1'b0;
      end
      if (rd_pend) begin
        if (buf_cnt == {1'b0, pop}) begin
          buf_data[0] <= regfft_rdata;
          buf_last[0] <= rd_pend_last;
        end else begin
          buf_data[1] <= regfft_rdata;
          buf_last[1] <= rd_pend_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfft_seq.sv
// Randomized bench for regfft_seq: a frame-level model (64 writes, then 64 reads
// in mapped order) checks every cycle; a register-file model sits beside the DUT.
module tb_regfft_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [37:0] in_data, out_data, regfft_wdata, regfft_rdata;
  logic        regfft_wren;
  logic [5:0]  regfft_addr;

  regfft_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .regfft_wren(regfft_wren), .regfft_addr(regfft_addr),
    .regfft_wdata(regfft_wdata), .regfft_rdata(regfft_rdata)
  );

  always #5 clk = ~clk;

  logic [37:0] mem [64];
  always @(posedge clk) begin
    if (regfft_wren) mem[regfft_addr] <= regfft_wdata;
    else             regfft_rdata     <= mem[regfft_addr];
  end

  int vecs = 0, errs = 0;
  int phase = 0, wr_idx = 0, rd_idx = 0, lat = 4, frames_done = 0;
  bit direct = 0, prev_stall = 0, prev_last = 0;
  logic [37:0] prev_data = '0;
  logic [37:0] frame [64];
  logic [37:0] lit [3];

  function automatic int mapf(input int i);
`ifdef REGFFT_BITREV_EN
    int r = 0;
    for (int b = 0; b < 6; b++) r += ((i >> b) & 1) << (5 - b);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
`ifdef REGFFT_BITREV_EN
    lit[0] = 38'd0; lit[1] = 38'd32; lit[2] = 38'd16;
`else
    lit[0] = 38'd0; lit[1] = 38'd1;  lit[2] = 38'd2;
`endif
  end

  // Monitor: checks against the frame model, then advances it for the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      phase = 0; wr_idx = 0; rd_idx = 0; lat = 4; prev_stall = 0;
    end else begin
      chk("in_ready", in_ready, phase == 0);
      chk("wren", regfft_wren, phase == 0 && in_valid);
      if (phase == 0 && in_valid) begin
        chk("waddr", regfft_addr, wr_idx);
        chk("wdata", regfft_wdata, in_data);
      end
      if (phase == 1) begin
        if (lat < 4) lat++;
        if (lat < 3)       chk("early_valid", out_valid, 1'b0);
        else if (lat == 3) chk("first_valid", out_valid, 1'b1);
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, prev_data);
          chk("stall_last", out_last, prev_last);
        end
        if (out_valid) begin
          chk("odata", out_data, frame[mapf(rd_idx)]);
          chk("olast", out_last, rd_idx == 63);
          if (direct && rd_idx < 3) chk("lit_order", out_data, lit[rd_idx]);
        end
      end else begin
        chk("idle_valid", out_valid, 1'b0);
      end
      prev_stall = phase == 1 && out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (phase == 0 && in_valid) begin
        frame[wr_idx] = in_data;
        if (wr_idx == 63) begin phase = 1; wr_idx = 0; rd_idx = 0; lat = 0; end
        else wr_idx++;
      end else if (phase == 1 && out_valid && out_ready) begin
        if (rd_idx == 63) begin phase = 0; frames_done++; end
        else rd_idx++;
      end
    end
  end

  // in_mode: 0 always, 1 alternate, 2 random. out_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
  task automatic run(input int in_mode, input int out_mode, input bit iso, input bit dir, input int stop_at);
    int start = frames_done;
    int cyc = 0;
    logic [63:0] r;
    direct = dir;
    while (frames_done == start && cyc < 3000) begin
      @(posedge clk); #1;
      if (stop_at >= 0 && phase == 1 && rd_idx >= stop_at) break;
      r = {$urandom, $urandom};
      case (in_mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2) == 0;
        default: in_valid = ($urandom % 3) != 0;
      endcase
      in_data = dir ? 38'(wr_idx) : r[37:0];
      if (iso && phase == 1) begin
        in_valid = 1'b1;
        in_data  = 38'h3F_FFFF_FFFF;
      end
      case (out_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = $urandom_range(0, 1) == 1;
      endcase
      cyc++;
    end
    if (stop_at < 0 && frames_done == start) begin
      vecs++; errs++;
      $display("FAIL timeout: frame not completed after %0d cycles", cyc);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b1;
    in_data  = 38'h3F_FFFF_FFFF;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 38'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wren", regfft_wren, 1'b0);
    chk("rst_addr", regfft_addr, 6'd0);
    chk("rst_wdata", regfft_wdata, 38'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    do_reset();
    run(0, 0, 0, 1, -1);
    run(1, 1, 0, 0, -1);
    run(0, 2, 1, 0, -1);
    run(2, 2, 1, 0, -1);
    run(0, 0, 0, 0, 21);
    do_reset();
    run(0, 0, 0, 1, -1);
    run(2, 1, 1, 0, -1);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfft_seq.md
REGFFT_SEQ -- requirements
Module: regfft_seq

Interface
REQ-001: The block SHALL provide port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002: The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003: The block SHALL provide port in_valid, input, 1 bit: input sample valid.
REQ-004: The block SHALL provide port in_ready, output, 1 bit: input sample accepted when in_valid and in_ready are both 1.
REQ-005: The block SHALL provide port in_data, input, 38 bits: input sample.
REQ-006: The block SHALL provide port out_valid, output, 1 bit: output sample valid.
REQ-007: The block SHALL provide port out_ready, input, 1 bit: downstream accepts the sample when out_valid and out_ready are both 1.
REQ-008: The block SHALL provide port out_data, output, 38 bits: output sample.
REQ-009: The block SHALL provide port out_last, output, 1 bit: marks the 64th output sample of a frame.
REQ-010: The block SHALL provide port regfft_wren, output, 1 bit: write enable to the 64x38 FFT register file.
REQ-011: The block SHALL provide port regfft_addr, output, 6 bits: register-file address.
REQ-012: The block SHALL provide port regfft_wdata, output, 38 bits: register-file write data.
REQ-013: The block SHALL provide port regfft_rdata, input, 38 bits: register-file read data, valid 1 cycle after a cycle with regfft_wren=0.

Function
REQ-014: The block SHALL implement a two-state FSM, FILL and DRAIN; reset enters FILL.
REQ-015: In FILL: in_ready=1; regfft_wren=in_valid (combinational); regfft_addr=wr_cnt; regfft_wdata=in_data; wr_cnt increments by 1 only on an accepted sample.
REQ-016: In FILL with in_valid=0: regfft_wren=0, regfft_addr holds wr_cnt, and no counter advances.
REQ-017: When the sample with wr_cnt=63 is accepted, the FSM SHALL move to DRAIN on the next edge, and wr_cnt SHALL wrap to 0.
REQ-018: In DRAIN: in_ready=0, regfft_wren=0, regfft_wdata is don't-care, and in_valid SHALL be ignored.
REQ-019: In DRAIN the block SHALL issue reads for rd_cnt 0..63 in order: regfft_addr=map(rd_cnt), and rd_cnt increments on each issued read.
REQ-020: A read SHALL be issued only when (buffered entries + in-flight reads) < 2, using a 2-entry output buffer.
REQ-021: regfft_rdata SHALL be captured into the output buffer on the cycle after the read is issued.
REQ-022: With out_ready held at 1, the first out_valid SHALL occur 2 cycles after entering DRAIN, and the block SHALL then deliver 1 sample per cycle with no bubbles.
REQ-023: While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; no sample SHALL be lost or duplicated.
REQ-024: out_last=1 SHALL accompany the sample read at rd_cnt=63.
REQ-025: On acceptance of the out_last sample, the FSM SHALL return to FILL on the next edge with rd_cnt=0; in_ready rises in that cycle.
REQ-026: Reads and writes SHALL never overlap.

Reset
REQ-027: While rst_n=0, all outputs SHALL immediately be: out_valid=0, out_last=0, out_data=0, in_ready=0, regfft_wren=0, regfft_addr=0, regfft_wdata=0.
REQ-028: Reset SHALL clear state to FILL, wr_cnt=0, rd_cnt=0, and the output buffer to empty.
REQ-029: A reset mid-frame SHALL discard the partial frame; register-file contents are not cleared.
REQ-030: After rst_n deasserts, in_ready=1 on the first cycle.

Configuration
REQ-031: With macro REGFFT_BITREV_EN defined, map(rd_cnt) SHALL be the 6-bit bit-reverse of rd_cnt, giving radix-2 DIT input order.
REQ-032: With REGFFT_BITREV_EN undefined, map(rd_cnt)=rd_cnt (natural order); all other behaviour is identical.

Verification
REQ-033: Bitrev: with REGFFT_BITREV_EN defined, write in_data=0..63 back-to-back with out_ready=1 -> outputs 0,32,16,48,8,40,...,63; out_last only on 63; first out_valid 3 cycles after the 64th accept.
REQ-034: Natural order: with REGFFT_BITREV_EN undefined and the same stimulus -> outputs 0,1,...,63 with out_last on 63.
REQ-035: Backpressure: out_ready toggling 1,0,0,1 repeating -> exactly 64 outputs in correct order; out_data stable during every stall; at most 2 reads outstanding.
REQ-036: Input gaps: in_valid asserted on alternate cycles -> regfft_wren pulses only on accepts; regfft_addr 0..63 with no skips; DRAIN entered only after 64 accepts.
REQ-037: Drain isolation: in_valid=1 with in_data=0x3FFFFFFFFF throughout DRAIN -> in_ready=0 and regfft_wren=0 for the whole drain; the value never appears at the output.
REQ-038: Reset mid-drain after output 20 -> out_valid=0 immediately; in_ready=1 after release; the next frame writes from address 0 and drains a full 64.
